prover_v_late_round_ctrl: RTL and testbench
===========================================

Name: prover_v_late_round_ctrl

Overview:
Round sequencer that drives prover_compute_v_late through one full late-phase sumcheck of 2*ninbits rounds. It issues the initial restart call, streams each round's coefficient triple out to the transcript/verifier link, and accepts the verifier challenge tau. From each tau it forms m_tau_p1 = (1 - tau) mod F_Q and issues the next call. It also captures the final h0/h1 claims. The block sits directly upstream of prover_compute_v_late, which it feeds, and consumes that block's c_out, h0 and h1.

Parameters:
ninbits, 3, input-layer address bits; total calls = 2*ninbits+1, coefficient rounds = 2*ninbits
nrndbits, $clog2(2*ninbits+1), round counter width; do not override (generate-time error if overridden)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse that begins a sumcheck; ignored unless idle
busy  out  1  high from the cycle after an accepted start until done/err
done  out  1  one-cycle pulse when h0_out/h1_out are valid
err  out  1  one-cycle pulse on out-of-range tau; sequence aborted
vl_en  out  1  one-cycle call pulse to prover_compute_v_late en
vl_restart  out  1  restart qualifier, high only on the round-0 call
vl_tau  out  F_NBITS  tau to v_late
vl_m_tau_p1  out  F_NBITS  (1-tau) mod F_Q to v_late
vl_ready  in  1  v_late ready (level)
vl_c  in  3*F_NBITS  v_late c_out[2:0]
vl_h0  in  F_NBITS  v_late h0_out
vl_h1  in  F_NBITS  v_late h1_out
coef_valid  out  1  coefficient triple valid
coef_ready  in  1  downstream accepts the triple
coef_out  out  3*F_NBITS  captured c[2:0]
coef_rnd  out  nrndbits  round index of coef_out
tau_valid  in  1  challenge available
tau_ready  out  1  block accepts a challenge
tau_in  in  F_NBITS  challenge value
h0_out, h1_out  out  F_NBITS  final claims, held until the next start

Behaviour:
- Reset: every output 0 and every register 0; state IDLE. vl_en is never high during or immediately after reset. Reset mid-sequence aborts with no done or err pulse.
- States and transitions:
  - IDLE: start → ISSUE, rnd=0, tau_reg=0, m_reg=1.
  - ISSUE: held until vl_ready=1. In the cycle vl_ready=1, drive vl_en=1 with vl_restart=(rnd==0) and vl_tau/vl_m_tau_p1 from tau_reg/m_reg; go to WAIT.
  - WAIT: ignore the cycle immediately after ISSUE, since v_late ready falls in that cycle. Then, on vl_ready=1:
    - rnd<2*ninbits: capture vl_c into coef_out and set coef_rnd=rnd; go to EMIT.
    - rnd==2*ninbits: capture vl_h0/vl_h1; pulse done; go to IDLE.
  - EMIT: coef_valid=1. On coef_valid&coef_ready go to TAU. coef_out is stable while valid.
  - TAU: tau_ready=1. On tau_valid:
    - tau_in<F_Q: latch tau_reg; go to PREP.
    - otherwise: pulse err; go to IDLE.
  - PREP: m_reg = (tau_reg<=1) ? 1-tau_reg : F_Q+1-tau_reg, computed at F_NBITS+1 width with no overflow; rnd++; go to ISSUE.
- vl_tau and vl_m_tau_p1 hold their values from PREP until the next PREP; v_late reads tau during its gates phase.
- tau_ready and coef_valid are never high together. An early tau_valid waits.
- busy=1 in every state except IDLE. start while busy is ignored, and a start in the same cycle as done is ignored.
- Minimum round latency with downstream always ready = 1 (ISSUE) + v_late latency + 1 (EMIT) + 1 (TAU) + 1 (PREP).

Decomposition:
- Package prover_round_ctrl_pkg: state enum {ST_IDLE, ST_ISSUE, ST_WAIT, ST_EMIT, ST_TAU, ST_PREP} and a function giving the total call count. F_Q and F_NBITS come from field_arith_defs.
- Sub-module field_one_minus: combinational (1-x) mod F_Q, reused by other round controllers.

Test Plan:
- ninbits=3, coef_ready tied 1, taus 2,3,4,5,6,7 → 7 vl_en pulses; vl_restart only on the first; coef_rnd 0..5 in order; done one cycle after the 7th vl_ready; h0_out=vl_h0, h1_out=vl_h1.
- tau_in=0 → vl_m_tau_p1=1; tau_in=1 → 0; tau_in=5 → F_Q-4; tau_in=F_Q-1 → 2.
- coef_ready held low 20 cycles → coef_valid and coef_out stable, tau_ready=0, no vl_en.
- tau_in=F_Q in round 2 → err pulse, busy drops, no further vl_en; a new start then runs from round 0.
- rst asserted during WAIT of round 3 → all outputs 0 in the same cycle; no done; clean restart after release.
- start pulsed while busy, and start coinciding with done → both ignored; vl_en count unchanged.

Source files
------------

// File: rtl/field_arith_defs.sv
// field_arith_defs: prime-field constants shared by the prover datapath (Mersenne-61 field).
package field_arith_defs;
  localparam int F_NBITS = 61;
  localparam logic [F_NBITS-1:0] F_Q = {F_NBITS{1'b1}};
endpackage

// File: rtl/prover_round_ctrl_pkg.sv
// prover_round_ctrl_pkg: state encoding and call-count helper for the sumcheck round controllers.
package prover_round_ctrl_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_EMIT, ST_TAU, ST_PREP} state_t;
  function automatic int total_calls(input int ninbits);
    return 2 * ninbits + 1;
  endfunction
endpackage

// File: rtl/field_one_minus.sv
// field_one_minus: combinational (1 - x) mod F_Q for a reduced operand x < F_Q.
module field_one_minus
  import field_arith_defs::*;
(
  input  logic [F_NBITS-1:0] x,
  output logic [F_NBITS-1:0] y
);
  logic [F_NBITS:0] t;
  // One extra bit so F_Q + 1 - x never wraps before truncation.
  always_comb begin
    t = (x <= F_NBITS'(1)) ? (F_NBITS+1)'(1) - {1'b0, x}
                           : {1'b0, F_Q} + (F_NBITS+1)'(1) - {1'b0, x};
    y = F_NBITS'(t);
  end
endmodule

// File: rtl/prover_v_late_round_ctrl.sv
// prover_v_late_round_ctrl: sequences the 2*ninbits+1 calls of prover_compute_v_late,
// streaming per-round coefficients out and folding verifier challenges back in.
module prover_v_late_round_ctrl
  import field_arith_defs::*, prover_round_ctrl_pkg::*;
#(
  parameter int ninbits  = 3,
  parameter int nrndbits = $clog2(2 * ninbits + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   vl_en,
  output logic                   vl_restart,
  output logic [F_NBITS-1:0]     vl_tau,
  output logic [F_NBITS-1:0]     vl_m_tau_p1,
  input  logic                   vl_ready,
  input  logic [3*F_NBITS-1:0]   vl_c,
  input  logic [F_NBITS-1:0]     vl_h0,
  input  logic [F_NBITS-1:0]     vl_h1,
  output logic                   coef_valid,
  input  logic                   coef_ready,
  output logic [3*F_NBITS-1:0]   coef_out,
  output logic [nrndbits-1:0]    coef_rnd,
  input  logic                   tau_valid,
  output logic                   tau_ready,
  input  logic [F_NBITS-1:0]     tau_in,
  output logic [F_NBITS-1:0]     h0_out,
  output logic [F_NBITS-1:0]     h1_out
);
  localparam logic [nrndbits-1:0] last_rnd = nrndbits'(total_calls(ninbits) - 1);
  if (nrndbits != $clog2(total_calls(ninbits))) begin : g_bad_nrndbits
    $error("nrndbits is derived from ninbits and must not be overridden");
  end
  state_t               state;
  logic                 skip;
  logic [nrndbits-1:0]  rnd;
  logic [F_NBITS-1:0]   tau_lat;
  logic [F_NBITS-1:0]   m_next;
  field_one_minus u_one_minus (.x(tau_lat), .y(m_next));
  // The call is issued in the very cycle v_late reports ready.
  assign vl_en      = (state == ST_ISSUE) && vl_ready;
  assign vl_restart = vl_en && (rnd == '0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      skip        <= 1'b0;
      rnd         <= '0;
      tau_lat     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      vl_tau      <= '0;
      vl_m_tau_p1 <= '0;
      coef_valid  <= 1'b0;
      coef_out    <= '0;
      coef_rnd    <= '0;
      tau_ready   <= 1'b0;
      h0_out      <= '0;
      h1_out      <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: if (start && !done) begin
          state       <= ST_ISSUE;
          busy        <= 1'b1;
          rnd         <= '0;
          vl_tau      <= '0;
          vl_m_tau_p1 <= F_NBITS'(1);
        end
        ST_ISSUE: if (vl_ready) begin
          state <= ST_WAIT;
          skip  <= 1'b1;
        end
        // v_late's ready is still stale in the first WAIT cycle.
        ST_WAIT: if (skip) skip <= 1'b0;
        else if (vl_ready) begin
          if (rnd == last_rnd) begin
            h0_out <= vl_h0;
            h1_out <= vl_h1;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            coef_out   <= vl_c;
            coef_rnd   <= rnd;
            coef_valid <= 1'b1;
            state      <= ST_EMIT;
          end
        end
        ST_EMIT: if (coef_ready) begin
          coef_valid <= 1'b0;
          tau_ready  <= 1'b1;
          state      <= ST_TAU;
        end
        ST_TAU: if (tau_valid) begin
          tau_ready <= 1'b0;
          if (tau_in < F_Q) begin
            tau_lat <= tau_in;
            state   <= ST_PREP;
          end else begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_PREP: begin
          vl_tau      <= tau_lat;
          vl_m_tau_p1 <= m_next;
          rnd         <= rnd + nrndbits'(1);
          state       <= ST_ISSUE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prover_v_late_round_ctrl.sv
// tb_prover_v_late_round_ctrl: scoreboard bench with a simple v_late responder model.
module tb_prover_v_late_round_ctrl;
  import field_arith_defs::*;
  localparam int N  = 3;
  localparam int RB = $clog2(2 * N + 1);
  typedef logic [F_NBITS-1:0] fe_t;
  typedef struct packed { logic restart; fe_t tau; fe_t m; } call_t;
  typedef struct packed { logic [3*F_NBITS-1:0] c; logic [RB-1:0] r; } coef_t;
  typedef struct packed { fe_t h0; fe_t h1; } fin_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, done, err, vl_en, vl_restart, coef_valid, tau_ready;
  logic coef_ready = 1'b1, tau_valid = 1'b0, vl_ready;
  fe_t vl_tau, vl_m_tau_p1, vl_h0, vl_h1, h0_out, h1_out;
  fe_t tau_in = '0;
  logic [3*F_NBITS-1:0] vl_c, coef_out;
  logic [RB-1:0] coef_rnd;
  int checks = 0, fails = 0, n_en = 0, n_done = 0, n_err = 0;
  call_t exp_call[$];
  coef_t exp_coef[$];
  fin_t  exp_fin[$];
  call_t ec;
  coef_t eo;
  fin_t  ef;
  fe_t t1_tau[6] = '{61'd2, 61'd3, 61'd4, 61'd5, 61'd6, 61'd7};
  fe_t t1_m[6]   = '{F_Q - 61'd1, F_Q - 61'd2, F_Q - 61'd3, F_Q - 61'd4, F_Q - 61'd5, F_Q - 61'd6};
  fe_t t2_tau[6] = '{61'd0, 61'd1, 61'd5, F_Q - 61'd1, 61'd9, 61'd10};
  fe_t t2_m[6]   = '{61'd1, 61'd0, F_Q - 61'd4, 61'd2, F_Q - 61'd8, F_Q - 61'd9};

  prover_v_late_round_ctrl #(.ninbits(N)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .vl_en(vl_en), .vl_restart(vl_restart), .vl_tau(vl_tau), .vl_m_tau_p1(vl_m_tau_p1),
    .vl_ready(vl_ready), .vl_c(vl_c), .vl_h0(vl_h0), .vl_h1(vl_h1),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_out(coef_out), .coef_rnd(coef_rnd),
    .tau_valid(tau_valid), .tau_ready(tau_ready), .tau_in(tau_in),
    .h0_out(h0_out), .h1_out(h1_out)
  );

  always #5 clk = ~clk;

  // v_late stand-in: 3-cycle latency, results derived from the tau/m it was called with.
  int  cnt;
  fe_t lt, lm;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vl_ready <= 1'b1;
      cnt      <= 0;
      vl_c     <= '0;
      vl_h0    <= '0;
      vl_h1    <= '0;
      lt       <= '0;
      lm       <= '0;
    end else if (vl_en) begin
      vl_ready <= 1'b0;
      cnt      <= 3;
      lt       <= vl_tau;
      lm       <= vl_m_tau_p1;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        vl_ready <= 1'b1;
        vl_c     <= {lt + 61'd3, lt + 61'd2, lt + 61'd1};
        vl_h0    <= lt + 61'd100;
        vl_h1    <= ~lm;
      end
    end
  end

  task automatic check(input string name, input logic [191:0] got, input logic [191:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (vl_en) begin
      n_en++;
      if (exp_call.size() == 0) check("unexpected vl_en", 1, 0);
      else begin
        ec = exp_call.pop_front();
        check("vl_restart", vl_restart, ec.restart);
        check("vl_tau", vl_tau, ec.tau);
        check("vl_m_tau_p1", vl_m_tau_p1, ec.m);
      end
    end
    if (coef_valid && coef_ready) begin
      if (exp_coef.size() == 0) check("unexpected coef", 1, 0);
      else begin
        eo = exp_coef.pop_front();
        check("coef_out", coef_out, eo.c);
        check("coef_rnd", coef_rnd, eo.r);
      end
    end
    if (done) begin
      n_done++;
      if (exp_fin.size() == 0) check("unexpected done", 1, 0);
      else begin
        ef = exp_fin.pop_front();
        check("h0_out", h0_out, ef.h0);
        check("h1_out", h1_out, ef.h1);
      end
    end
    if (err) n_err++;
    check("coef_valid with tau_ready", coef_valid & tau_ready, 0);
  end

  task automatic push_call(input logic rs, input fe_t t, input fe_t m);
    exp_call.push_back('{restart: rs, tau: t, m: m});
  endtask

  task automatic push_coef(input fe_t t, input int rr);
    exp_coef.push_back('{c: {t + 61'd3, t + 61'd2, t + 61'd1}, r: RB'(rr)});
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic give_tau(input fe_t t);
    int k = 0;
    tau_valid = 1'b1;
    tau_in = t;
    while (!tau_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) check("tau handshake timeout", 0, 1);
    else @(negedge clk);
    tau_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " ctl"}, {busy, done, err, vl_en, vl_restart, coef_valid, tau_ready, coef_rnd}, 0);
    check({tag, " vl_tau"}, vl_tau, 0);
    check({tag, " vl_m_tau_p1"}, vl_m_tau_p1, 0);
    check({tag, " coef_out"}, coef_out, 0);
    check({tag, " h0_out"}, h0_out, 0);
    check({tag, " h1_out"}, h1_out, 0);
  endtask

  task automatic run_full(input fe_t tv[6], input fe_t mv[6], input fe_t h0v, input fe_t h1v,
                          input bit stall, input bit extra_starts);
    int base = n_en;
    int k = 0;
    bit ok = 1'b1;
    bit seen = 1'b0;
    logic [3*F_NBITS-1:0] saved;
    push_call(1'b1, 61'd0, 61'd1);
    push_coef(61'd0, 0);
    coef_ready = !stall;
    pulse_start();
    check("busy after start", busy, 1);
    if (stall) begin
      while (!coef_valid && k < 100) begin
        @(negedge clk);
        k++;
      end
      check("coef_valid before stall", coef_valid, 1);
      saved = coef_out;
      tau_valid = 1'b1;
      tau_in = tv[0];
      repeat (20) begin
        @(negedge clk);
        if (!coef_valid || coef_out !== saved || tau_ready || vl_en) ok = 1'b0;
      end
      check("coef stall hold", ok, 1);
      coef_ready = 1'b1;
    end
    for (int r = 1; r <= 6; r++) begin
      push_call(1'b0, tv[r-1], mv[r-1]);
      if (r < 6) push_coef(tv[r-1], r);
      else exp_fin.push_back('{h0: h0v, h1: h1v});
      give_tau(tv[r-1]);
      if (extra_starts && r == 3) pulse_start();
    end
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        if (extra_starts) start = 1'b1;
      end
    end
    check("done seen", seen, 1);
    @(negedge clk) start = 1'b0;
    repeat (10) @(negedge clk);
    check("busy idle after run", busy, 0);
    check("vl_en per run", n_en - base, 7);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, e0, d0, k;
    repeat (3) @(negedge clk);
    check_zero("in reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("after reset");
    // Coefficient stall plus the one-minus corner values.
    run_full(t2_tau, t2_m, 61'd110, 61'd9, 1'b1, 1'b0);
    // Out-of-range tau aborts in round 2.
    base = n_en;
    e0 = n_err;
    push_call(1'b1, 61'd0, 61'd1);
    push_coef(61'd0, 0);
    pulse_start();
    push_call(1'b0, 61'd2, F_Q - 61'd1);
    push_coef(61'd2, 1);
    give_tau(61'd2);
    push_call(1'b0, 61'd3, F_Q - 61'd2);
    push_coef(61'd3, 2);
    give_tau(61'd3);
    give_tau(F_Q);
    check("err pulse", err, 1);
    check("busy after err", busy, 0);
    repeat (10) @(negedge clk);
    check("vl_en after err", n_en - base, 3);
    check("err count", n_err - e0, 1);
    // Fresh run after abort, with a start mid-run and a start on done.
    run_full(t1_tau, t1_m, 61'd107, 61'd6, 1'b0, 1'b1);
    // Reset in WAIT of round 3.
    base = n_en;
    d0 = n_done;
    push_call(1'b1, 61'd0, 61'd1);
    push_coef(61'd0, 0);
    pulse_start();
    push_call(1'b0, 61'd2, F_Q - 61'd1);
    push_coef(61'd2, 1);
    give_tau(61'd2);
    push_call(1'b0, 61'd3, F_Q - 61'd2);
    push_coef(61'd3, 2);
    give_tau(61'd3);
    push_call(1'b0, 61'd4, F_Q - 61'd3);
    give_tau(61'd4);
    k = 0;
    while (!vl_en && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("round 3 call seen", vl_en, 1);
    @(negedge clk);
    check("busy in wait", busy, 1);
    #1 rst = 1'b1;
    #1 check_zero("async reset");
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);
    check("busy after mid reset", busy, 0);
    check("no done after reset", n_done - d0, 0);
    check("calls before reset", n_en - base, 4);
    check("call queue drained", exp_call.size(), 0);
    check("coef queue drained", exp_coef.size(), 0);
    run_full(t1_tau, t1_m, 61'd107, 61'd6, 1'b0, 1'b0);
    check("final call queue", exp_call.size(), 0);
    check("final coef queue", exp_coef.size(), 0);
    check("final fin queue", exp_fin.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
